char2num: RTL

- Receive-side counterpart of num2char: parses a stream of ASCII decimal characters, one per cycle, into a 32-bit unsigned value.
- Sits behind the UART/character receive path. Delivers host-entered numbers (thresholds, expected error_rate values) to the control logic as a registered value with a one-cycle valid pulse.
- A malformed or out-of-range line produces an error pulse instead of a value.

---
 rtl/char2num.sv | 125 ++++++++++++
 1 files changed

// File: rtl/char2num.sv
// char2num: parses a stream of ASCII decimal characters into an unsigned value.
// Ports: CLK/RST (sync, active-high), char/valid_i (one char per valid cycle),
//        value_o (last parsed value), valid_o/error_o (one-cycle pulses),
//        busy_o (a line is partially received).
module char2num #(
   parameter int MAX_DIGITS = 10,
   parameter int WIDTH      = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       char,
   input  logic             valid_i,
   output logic [WIDTH-1:0] value_o,
   output logic             valid_o,
   output logic             error_o,
   output logic             busy_o
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic             busy_q;

   logic             is_dig;
   logic             is_term;
   logic             is_sp;
   logic [3:0]       dig;
   logic [WIDTH+3:0] acc_x;
   logic [WIDTH+3:0] nxt;
   logic             ovf;

   assign is_dig  = (char >= 8'h30) && (char <= 8'h39);
   assign is_term = (char == 8'h0D) || (char == 8'h0A);
   assign is_sp   = (char == 8'h20);
   assign dig     = char[3:0];

   // acc*10 + d, kept wide enough that any overflow shows in the top bits
   assign acc_x = {4'b0000, acc_q};
   assign nxt   = (acc_x << 3) + (acc_x << 1) + {{WIDTH{1'b0}}, dig};
   assign ovf   = (nxt[WIDTH+3:WIDTH] != 4'b0000);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      if (valid_i) begin
         unique case (state_q)
            IDLE: begin
               if (is_dig) begin
                  acc_d   = {{(WIDTH-4){1'b0}}, dig};
                  cnt_d   = CW'(1);
                  state_d = ACC;
               end else if (!(is_term || is_sp)) begin
                  state_d = ERR;
               end
            end
            ACC: begin
               if (is_dig) begin
                  if (ovf || (cnt_q == MAXC)) begin
                     state_d = ERR;
                  end else begin
                     acc_d = nxt[WIDTH-1:0];
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (is_term) begin
                  value_d = acc_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ERR;
               end
            end
            ERR: begin
               // swallow the rest of the line, report once at its end
               if (is_term) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         valid_q <= valid_d;
         error_q <= error_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign value_o = value_q;
   assign valid_o = valid_q;
   assign error_o = error_q;
   assign busy_o  = busy_q;

endmodule
